fir_seq_ctrl: RTL

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_tap_counter.sv | 27 ++
 rtl/fir_seq_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencing controller: the state encoding
// and the default geometry of the filter.
package fir_pkg;

   localparam int DEFAULT_MAX_TAPS = 64;
   localparam int DEFAULT_NUM_CH   = 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PRIME,
      EXEC,
      OUT
   } fir_state_t;

endpackage

// File: rtl/fir_tap_counter.sv
// Tap address counter: synchronous clear to zero, count enable, and a flag
// raised while the count sits on the last tap of the current operation.
module fir_tap_counter #(
   parameter int AW = 6,
   parameter int TW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          enable,
   input  logic [TW-1:0] limit,
   output logic [AW-1:0] count,
   output logic          terminal
);

   // The limit is a tap count (>= 1), so the last address is limit-1.
   assign terminal = (TW'(count) == (limit - TW'(1)));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + AW'(1);
      end
   end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a multi-channel FIR datapath: accepts one sample, shifts it
// into the channel's delay line, walks N taps, then holds the result.
module fir_seq_ctrl
   import fir_pkg::*;
#(
   parameter int MAX_TAPS = DEFAULT_MAX_TAPS,
   parameter int NUM_CH   = DEFAULT_NUM_CH,
   localparam int AW = $clog2(MAX_TAPS),
   localparam int TW = $clog2(MAX_TAPS + 1),
   localparam int CW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_ch,
   input  logic [TW-1:0] num_taps,
   output logic [AW-1:0] address,
   output logic [CW-1:0] ch_sel,
   output logic          shift,
   output logic          flush,
   output logic          acc_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          freeze,
   output logic [CW-1:0] out_ch,
   output logic          busy
);

   localparam logic [TW-1:0] MAX_N = TW'(MAX_TAPS);

   fir_state_t    state;
   fir_state_t    stateNext;
   logic [CW-1:0] chSel;
   logic [TW-1:0] nTaps;
   logic [TW-1:0] nEff;
   logic          accept;
   logic          counterEn;
   logic          counterClear;
   logic          tapLast;

   assign accept = in_valid && (state == IDLE);
   assign nEff   = ((num_taps == '0) || (num_taps > MAX_N)) ? MAX_N : num_taps;

   assign busy   = (state != IDLE);
   assign ch_sel = chSel;
   assign out_ch = chSel;

   // The counter rests at zero outside EXEC and is reloaded on the last tap,
   // so LOAD, PRIME and a stalled OUT all present address 0.
   assign counterClear = (state != EXEC) || tapLast;

   fir_tap_counter #(
      .AW(AW),
      .TW(TW)
   ) tapCounter (
      .clk     (clk),
      .rst     (rst),
      .clear   (counterClear),
      .enable  (counterEn),
      .limit   (nTaps),
      .count   (address),
      .terminal(tapLast)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Channel and tap count are captured only on accept so that input changes
   // during an operation cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         chSel <= '0;
         nTaps <= MAX_N;
      end else if (accept) begin
         chSel <= in_ch;
         nTaps <= nEff;
      end
   end

   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      shift     = 1'b0;
      flush     = 1'b0;
      acc_en    = 1'b0;
      out_valid = 1'b0;
      freeze    = 1'b0;
      counterEn = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) stateNext = LOAD;
         end
         LOAD: begin
            shift     = 1'b1;
            flush     = 1'b1;
            stateNext = PRIME;
         end
         PRIME: begin
            stateNext = EXEC;
         end
         EXEC: begin
            acc_en    = 1'b1;
            counterEn = 1'b1;
            if (tapLast) stateNext = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            freeze    = 1'b1;
            if (out_ready) stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

endmodule
